// File: rtl/mult_error_monitor.sv
// Error statistics monitor for an approximate signed multiplier: over a run of
// N_SAMPLES accepted samples it counts mismatches and tracks sum/max of |error|.
module mult_error_monitor #(
  parameter int W         = 4,
  parameter int N_SAMPLES = 256,
  parameter int SUM_W     = 16,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [W-1:0]        y_approx,
  input  logic [W-1:0]        y_exact,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_count,
  output logic [CNT_W-1:0]    err_count,
  output logic [SUM_W-1:0]    sum_abs_err,
  output logic [W-1:0]        max_abs_err
);

  // Accumulator add is done one bit wider than the larger operand so the
  // carry out is visible for saturation even when SUM_W < W.
  localparam int ACC_W = ((SUM_W > W) ? SUM_W : W) + 1;
  localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W - SUM_W){1'b0}}, {SUM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [W-1:0]       max_q, max_d;
  logic               busy_q, done_q;

  logic signed [W:0]  diff;
  logic [W-1:0]       abs_err;
  logic [ACC_W-1:0]   sum_ext;

  always_comb begin
    diff    = $signed({y_approx[W-1], y_approx}) - $signed({y_exact[W-1], y_exact});
    abs_err = diff[W] ? W'(-diff) : W'(diff);
    sum_ext = ACC_W'(sum_q) + ACC_W'(abs_err);

    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (diff != '0) err_d = err_q + CNT_W'(1);
          if (abs_err > max_q) max_d = abs_err;
          sum_d = (sum_ext > SUM_MAX) ? '1 : SUM_W'(sum_ext);
          if (cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;

endmodule
